hazard_sequencer: RTL and testbench

//  Pipeline hazard sequencer driving the IF/ID stage-register mode select, PC write enable and ID/EX bubble.

---
 rtl/hazard_sequencer.sv | 96 +++++++++
 tb/tb_hazard_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use / branch / jump hazard FSM driving IF/ID mode, PC write and ID/EX bubble.
// Optional stall/flush performance counters are built only when HAZARD_SEQ_PERF_EN is defined.
module hazard_sequencer #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             id_jump,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic [1:0]       if_id_mux,
    output logic             pc_write,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, LU_WAIT, FREEZE} state_t;
    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);
    state_t     state, state_nxt, saved, saved_nxt, eff;
    logic [3:0] wcnt, wcnt_nxt;
    logic       lu;
    assign lu = ex_mem_read && ex_rd != 5'd0 &&
                ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            saved <= RUN;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            saved <= saved_nxt;
            wcnt  <= wcnt_nxt;
        end
    end
    // A released freeze behaves in the same cycle as the state it interrupted.
    always_comb begin
        eff         = (state == FREEZE) ? saved : state;
        state_nxt   = eff;
        saved_nxt   = saved;
        wcnt_nxt    = wcnt;
        if_id_mux   = 2'b00;
        pc_write    = 1'b1;
        id_ex_flush = 1'b0;
        if (mem_busy) begin
            if_id_mux = 2'b10;
            pc_write  = 1'b0;
            state_nxt = FREEZE;
            saved_nxt = eff;
        end else if (ex_br_taken) begin
            if_id_mux   = 2'b01;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
            wcnt_nxt    = 4'd0;
        end else if (eff == LU_WAIT) begin
            if_id_mux   = 2'b10;
            pc_write    = 1'b0;
            id_ex_flush = 1'b1;
            wcnt_nxt    = wcnt - 4'd1;
            state_nxt   = (wcnt == 4'd1) ? RUN : LU_WAIT;
        end else if (lu) begin
            if_id_mux   = 2'b10;
            pc_write    = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nxt = LU_WAIT;
                wcnt_nxt  = LAT_M1;
            end
        end else if (id_jump) begin
            if_id_mux = 2'b01;
        end
    end
`ifdef HAZARD_SEQ_PERF_EN
    logic [CNT_W-1:0] sc_q, fc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= '0;
            fc_q <= '0;
        end else begin
            if (!pc_write && !(&sc_q)) sc_q <= sc_q + 1'b1;
            if (if_id_mux == 2'b01 && !(&fc_q)) fc_q <= fc_q + 1'b1;
        end
    end
    assign stall_cnt = sc_q;
    assign flush_cnt = fc_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: three sequencer instances (LOAD_LAT 1/3/3, CNT_W 16/16/2) checked each cycle
// against a stall-budget model, plus directed literal expectations.
module tb_hazard_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_mem_read, id_jump, ex_br_taken, mem_busy;
    logic [1:0] mux0, mux1, mux2;
    logic       pcw0, pcw1, pcw2, fl0, fl1, fl2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;
    int n_vec = 0, n_fail = 0;
    always #5 clk = ~clk;

    hazard_sequencer #(.LOAD_LAT(1), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_jump(id_jump), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .if_id_mux(mux0),
        .pc_write(pcw0), .id_ex_flush(fl0), .stall_cnt(sc0), .flush_cnt(fc0));
    hazard_sequencer #(.LOAD_LAT(3), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_jump(id_jump), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .if_id_mux(mux1),
        .pc_write(pcw1), .id_ex_flush(fl1), .stall_cnt(sc1), .flush_cnt(fc1));
    hazard_sequencer #(.LOAD_LAT(3), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_jump(id_jump), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .if_id_mux(mux2),
        .pc_write(pcw2), .id_ex_flush(fl2), .stall_cnt(sc2), .flush_cnt(fc2));

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Model: remaining stall cycles per instance plus saturating event tallies.
    int lat[3] = '{1, 3, 3};
    int cmax[3] = '{65535, 65535, 3};
    int rem[3], scm[3], fcm[3];
    always @(negedge clk) begin
        int em, ep, ef, am, ap, af, asc, afc;
        bit lu;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        for (int k = 0; k < 3; k++) begin
            em = 0; ep = 1; ef = 0;
            if (!rst_n) begin
                rem[k] = 0; scm[k] = 0; fcm[k] = 0;
            end else if (mem_busy) begin
                em = 2; ep = 0;
            end else if (ex_br_taken) begin
                em = 1; ef = 1; rem[k] = 0;
            end else if (rem[k] > 0) begin
                em = 2; ep = 0; ef = 1; rem[k]--;
            end else if (lu) begin
                em = 2; ep = 0; ef = 1; rem[k] = lat[k] - 1;
            end else if (id_jump) begin
                em = 1;
            end
            am  = (k == 0) ? int'(mux0) : (k == 1) ? int'(mux1) : int'(mux2);
            ap  = (k == 0) ? int'(pcw0) : (k == 1) ? int'(pcw1) : int'(pcw2);
            af  = (k == 0) ? int'(fl0)  : (k == 1) ? int'(fl1)  : int'(fl2);
            asc = (k == 0) ? int'(sc0)  : (k == 1) ? int'(sc1)  : int'(sc2);
            afc = (k == 0) ? int'(fc0)  : (k == 1) ? int'(fc1)  : int'(fc2);
            chk("if_id_mux", k, am, em);
            chk("pc_write", k, ap, ep);
            chk("id_ex_flush", k, af, ef);
`ifdef HAZARD_SEQ_PERF_EN
            chk("stall_cnt", k, asc, scm[k]);
            chk("flush_cnt", k, afc, fcm[k]);
            if (rst_n && ep == 0 && scm[k] < cmax[k]) scm[k]++;
            if (rst_n && em == 1 && fcm[k] < cmax[k]) fcm[k]++;
`else
            chk("stall_cnt", k, asc, 0);
            chk("flush_cnt", k, afc, 0);
`endif
        end
    end

    task automatic drv(input bit busy, input bit br, input bit mr, input int rd, input int rs, input int rt,
                       input bit urs, input bit urt, input bit jmp);
        @(posedge clk);
        #1;
        mem_busy = busy; ex_br_taken = br; ex_mem_read = mr; ex_rd = 5'(rd);
        id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt; id_jump = jmp;
        @(negedge clk);
    endtask
    task automatic idle(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic ld(); drv(0, 0, 1, 5, 5, 0, 1, 0, 0); endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        {mem_busy, ex_br_taken, ex_mem_read, id_use_rs, id_use_rt, id_jump} = '0;
        {ex_rd, id_rs, id_rt} = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int exp_s, exp_f;
        rst_n = 1'b0;
        {mem_busy, ex_br_taken, ex_mem_read, id_use_rs, id_use_rt, id_jump} = '0;
        {ex_rd, id_rs, id_rt} = '0;
        @(negedge clk);
        chk("lit_reset_mux", 1, int'(mux1), 0);
        chk("lit_reset_pcw", 1, int'(pcw1), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // load-use, LOAD_LAT 1 vs 3
        ld();
        chk("lit_lu_mux", 0, int'(mux0), 2);
        chk("lit_lu_pcw", 0, int'(pcw0), 0);
        chk("lit_lu_fl", 0, int'(fl0), 1);
        idle();
        chk("lit_lu_rel", 0, int'(mux0), 0);
        chk("lit_lu_wait", 1, int'(mux1), 2);
        idle();
        chk("lit_lu_wait3", 1, int'(mux1), 2);
        idle();
        chk("lit_lu_done", 1, int'(mux1), 0);
        // branch aborts wait
        ld();
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_br_mux", 1, int'(mux1), 1);
        chk("lit_br_pcw", 1, int'(pcw1), 1);
        idle();
        chk("lit_br_run", 1, int'(mux1), 0);
        // jump, and $zero never stalls
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_jmp_mux", 0, int'(mux0), 1);
        chk("lit_jmp_fl", 0, int'(fl0), 0);
        drv(0, 0, 1, 0, 0, 0, 1, 1, 0);
        chk("lit_zero_mux", 1, int'(mux1), 0);
        // freeze during wait keeps remaining count
        ld();
        repeat (4) begin
            drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("lit_frz_mux", 1, int'(mux1), 2);
            chk("lit_frz_fl", 1, int'(fl1), 0);
        end
        idle();
        chk("lit_frz_w1", 1, int'(fl1), 1);
        idle();
        chk("lit_frz_w2", 1, int'(fl1), 1);
        idle();
        chk("lit_frz_end", 1, int'(mux1), 0);
        // reset in the middle of a wait
        ld();
        idle();
        do_reset();
        idle();
        chk("lit_rst_mux", 1, int'(mux1), 0);
        chk("lit_rst_pcw", 1, int'(pcw1), 1);
        chk("lit_rst_sc", 1, int'(sc1), 0);
        // counters: 3 stalls + 2 flushes on inst0
        do_reset();
        ld(); idle(); ld(); idle(); ld();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
`ifdef HAZARD_SEQ_PERF_EN
        exp_s = 3; exp_f = 2;
`else
        exp_s = 0; exp_f = 0;
`endif
        chk("lit_stall_cnt", 0, int'(sc0), exp_s);
        chk("lit_flush_cnt", 0, int'(fc0), exp_f);
        chk("lit_sat_cnt", 2, int'(sc2), exp_s);
        // randomized traffic with a small register space to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else drv($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
